// File: rtl/wb_queue_if.sv
// wb_queue_if: producer, drain and status signals of the writeback queue
interface wb_queue_if #(parameter int DEPTH = 4, parameter int XLEN = 32);
    logic                     alu_valid;
    logic                     alu_ready;
    logic [4:0]               alu_rd;
    logic [XLEN-1:0]          alu_data;
    logic                     ld_valid;
    logic                     ld_ready;
    logic [4:0]               ld_rd;
    logic [XLEN-1:0]          ld_data;
    logic [2:0]               ld_funct3;
    logic [1:0]               ld_addr_lo;
    logic                     hold;
    logic                     rf_write_ena;
    logic [4:0]               rf_write_addr;
    logic [XLEN-1:0]          rf_write_data;
    logic [31:0]              pending_mask;
    logic [$clog2(DEPTH):0]   count;
    modport master (
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, ld_funct3, ld_addr_lo, hold,
        input  alu_ready, ld_ready, rf_write_ena, rf_write_addr, rf_write_data, pending_mask, count
    );
    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, ld_funct3, ld_addr_lo, hold,
        output alu_ready, ld_ready, rf_write_ena, rf_write_addr, rf_write_data, pending_mask, count
    );
endinterface

// File: rtl/wb_queue.sv
// wb_queue: writeback FIFO from ALU/load producers to the register file; WB_LOAD_EXT_EN enables lb/lh/lbu/lhu extraction
module wb_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    wb_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    logic [4:0]      rd_q [DEPTH];
    logic [4:0]      rd_d [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [XLEN-1:0] data_d [DEPTH];
    logic [AW-1:0]   rptr_q, rptr_d, wptr_q, wptr_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic            full, push, pop;
    logic [4:0]      push_rd;
    logic [XLEN-1:0] push_data, ld_val;
    logic [31:0]     mask;
`ifdef WB_LOAD_EXT_EN
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    always_comb begin
        ld_b   = bus.ld_data[{bus.ld_addr_lo, 3'b000} +: 8];
        ld_h   = bus.ld_addr_lo[1] ? bus.ld_data[31:16] : bus.ld_data[15:0];
        ld_val = bus.ld_funct3 == 3'b000 ? {{(XLEN-8){ld_b[7]}}, ld_b} :
                 bus.ld_funct3 == 3'b001 ? {{(XLEN-16){ld_h[15]}}, ld_h} :
                 bus.ld_funct3 == 3'b100 ? {{(XLEN-8){1'b0}}, ld_b} :
                 bus.ld_funct3 == 3'b101 ? {{(XLEN-16){1'b0}}, ld_h} : bus.ld_data;
    end
`else
    assign ld_val = bus.ld_data;
`endif
    always_comb begin
        full      = cnt_q == (AW+1)'(DEPTH);
        pop       = cnt_q != '0 && !bus.hold;
        push_rd   = bus.ld_valid ? bus.ld_rd : bus.alu_rd;
        push_data = bus.ld_valid ? ld_val : bus.alu_data;
        // rd==0 handshakes complete but never occupy a slot
        push      = !full && (bus.ld_valid || bus.alu_valid) && push_rd != 5'd0;
        rd_d      = rd_q;
        data_d    = data_q;
        if (push) begin
            rd_d[wptr_q]   = push_rd;
            data_d[wptr_q] = push_data;
        end
        wptr_d = wptr_q + AW'(push);
        rptr_d = rptr_q + AW'(pop);
        cnt_d  = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        mask   = '0;
        for (int i = 0; i < DEPTH; i++)
            if ({1'b0, AW'(AW'(i) - rptr_q)} < cnt_q) mask[rd_q[i]] = 1'b1;
    end
    assign bus.ld_ready      = !full;
    assign bus.alu_ready     = !full && !bus.ld_valid;
    assign bus.rf_write_ena  = pop;
    assign bus.rf_write_addr = rd_q[rptr_q];
    assign bus.rf_write_data = data_q[rptr_q];
    assign bus.pending_mask  = mask;
    assign bus.count         = cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
            rd_q   <= rd_d;
            data_q <= data_d;
        end
    end
endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: randomized scoreboard bench for wb_queue against a queue-based reference model
module tb_wb_queue;
    localparam int DEPTH = 4;
`ifdef WB_LOAD_EXT_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif
    typedef struct { logic [4:0] rd; logic [31:0] d; } ent_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    ent_t sbq[$];
    wb_queue_if #(.DEPTH(DEPTH), .XLEN(32)) bus ();
    wb_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    function automatic logic [31:0] ext_model(input logic [31:0] w, input logic [2:0] f, input logic [1:0] a);
        logic [31:0] b, h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        if (!EXT) return w;
        case (f)
            3'b000:  return (b ^ 32'h80) - 32'h80;
            3'b001:  return (h ^ 32'h8000) - 32'h8000;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] mask_model();
        logic [31:0] m = 0;
        foreach (sbq[i]) m = m | (32'h1 << sbq[i].rd);
        return m;
    endfunction

    task automatic cyc(input logic h, input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                       input logic [2:0] f3, input logic [1:0] lo);
        logic full, la, aa;
        @(negedge clk);
        bus.hold = h; bus.alu_valid = av; bus.alu_rd = ar; bus.alu_data = ad;
        bus.ld_valid = lv; bus.ld_rd = lr; bus.ld_data = ld; bus.ld_funct3 = f3; bus.ld_addr_lo = lo;
        #1;
        full = sbq.size() == DEPTH;
        chk("ld_ready", 32'(bus.ld_ready), 32'(!full));
        chk("alu_ready", 32'(bus.alu_ready), 32'(!full && !lv));
        chk("count", 32'(bus.count), 32'(sbq.size()));
        chk("pending_mask", bus.pending_mask, mask_model());
        la = lv && !full;
        aa = av && !full && !lv;
        #2;
        if (la && lr != 0) sbq.push_back('{lr, ext_model(ld, f3, lo)});
        else if (aa && ar != 0) sbq.push_back('{ar, ad});
    endtask

    task automatic idle(input logic h);
        cyc(h, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic alu(input logic h, input logic [4:0] r, input logic [31:0] d);
        cyc(h, 1, r, d, 0, 0, 0, 0, 0);
    endtask

    task automatic load(input logic [4:0] r, input logic [31:0] d, input logic [2:0] f, input logic [1:0] a);
        cyc(0, 0, 0, 0, 1, r, d, f, a);
    endtask

    initial begin : monitor
        ent_t e;
        forever begin
            @(negedge clk);
            #2;
            chk("rf_write_ena", 32'(bus.rf_write_ena), 32'(sbq.size() > 0 && !bus.hold));
            if (bus.rf_write_ena === 1'b1 && sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("rf_write_addr", 32'(bus.rf_write_addr), 32'(e.rd));
                chk("rf_write_data", bus.rf_write_data, e.d);
            end
        end
    end

    initial begin : driver
        bus.hold = 0; bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
        bus.ld_valid = 0; bus.ld_rd = 0; bus.ld_data = 0; bus.ld_funct3 = 0; bus.ld_addr_lo = 0;
        @(negedge clk);
        #1;
        chk("rst_alu_ready", 32'(bus.alu_ready), 1);
        chk("rst_ld_ready", 32'(bus.ld_ready), 1);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_pending", bus.pending_mask, 0);
        chk("rst_addr", 32'(bus.rf_write_addr), 0);
        chk("rst_data", bus.rf_write_data, 0);
        rst_n = 1;
        // single ALU result, then concurrent producers with load winning
        alu(0, 5'd5, 32'h1234_5678);
        idle(0);
        idle(0);
        cyc(0, 1, 5'd4, 32'hAAAA_0004, 1, 5'd3, 32'h0000_0333, 3'b010, 0);
        alu(0, 5'd4, 32'hAAAA_0004);
        idle(0);
        idle(0);
        // fill under hold, then release
        for (int i = 1; i <= 5; i++) alu(1, 5'(i + 10), 32'h100 + 32'(i));
        idle(1);
        idle(1);
        for (int i = 0; i < 5; i++) idle(0);
        // load extraction cases
        load(5'd7, 32'h80FF_7F01, 3'b000, 2'd1);
        load(5'd8, 32'h80FF_7F01, 3'b100, 2'd3);
        load(5'd9, 32'h80FF_7F01, 3'b001, 2'd2);
        load(5'd10, 32'h80FF_7F01, 3'b101, 2'd0);
        load(5'd11, 32'h80FF_7F01, 3'b010, 2'd1);
        idle(0);
        chk("lb_const", ext_model(32'h80FF_7F01, 3'b000, 2'd1), EXT ? 32'h0000_007F : 32'h80FF_7F01);
        // rd=0 accepted without enqueue
        alu(0, 5'd0, 32'hDEAD_BEEF);
        idle(0);
        idle(0);
        // reset with three queued entries
        for (int i = 0; i < 3; i++) alu(1, 5'(i + 20), 32'h200 + 32'(i));
        @(negedge clk);
        bus.hold = 0; bus.alu_valid = 0; bus.ld_valid = 0;
        rst_n = 0;
        sbq.delete();
        #1;
        chk("mid_rst_ena", 32'(bus.rf_write_ena), 0);
        chk("mid_rst_count", 32'(bus.count), 0);
        chk("mid_rst_pending", bus.pending_mask, 0);
        chk("mid_rst_ready", 32'({bus.alu_ready, bus.ld_ready}), 3);
        @(negedge clk);
        #1;
        rst_n = 1;
        idle(0);
        idle(0);
        // randomized traffic
        for (int n = 0; n < 2000; n++)
            cyc($urandom_range(3) == 0, 1'($urandom_range(1)), 5'($urandom_range(31)), $urandom,
                $urandom_range(2) == 0, 5'($urandom_range(31)), $urandom,
                3'($urandom_range(7)), 2'($urandom_range(3)));
        for (int i = 0; i < DEPTH + 2; i++) idle(0);
        chk("final_empty", 32'(sbq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
